// File: rtl/branch_pc_sequencer.sv
// Program-counter and control-flow sequencer for the RISC-V core.
// Holds the PC and resolves JAL, JALR and the six conditional branches.
// A taken jump or branch whose target is not 4-byte aligned redirects to
// TRAP_VECTOR instead, and the faulting PC and target are recorded.
// After a taken redirect the sequencer can idle for a number of bubble cycles.
module branch_pc_sequencer #(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_PC         = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR      = XLEN'('h100),
  parameter int              REDIRECT_BUBBLES = 0,
  parameter int              CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  output logic [XLEN-1:0]  pc,
  output logic             link_we,
  output logic [4:0]       link_rd,
  output logic [XLEN-1:0]  link_value,
  output logic             bubble,
  output logic             trap,
  output logic [XLEN-1:0]  fault_pc,
  output logic [XLEN-1:0]  fault_target,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {RUN, BUBBLE} state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] BUB_INIT  = 2'(REDIRECT_BUBBLES);

  state_t          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [XLEN-1:0] pc_d, fault_pc_d, fault_target_d;
  logic [CNT_W-1:0] count_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_jal, is_jalr, is_branch, is_jump;
  logic [XLEN-1:0] imm_i, imm_b, imm_j;
  logic [XLEN-1:0] target;
  logic            cond, taken, misaligned, run;

  // Field extraction and immediate sign extension.
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign link_rd   = instr[11:7];
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = is_jal | is_jalr;

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Branch condition selected by funct3; 010/011 are never taken.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val <  rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  // Redirect target; JALR clears bit 0 of its sum, all sums wrap.
  always_comb begin
    target = pc + (is_jal ? imm_j : imm_b);
    if (is_jalr) begin
      target = (rs1_val + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
    end
  end

  assign taken      = is_jump | (is_branch & cond);
  assign misaligned = taken & (target[1:0] != 2'b00);
  assign run        = (state_q == RUN);

  assign link_value = pc + XLEN'(4);
  assign link_we    = run & advance & is_jump & (link_rd != 5'd0) & ~misaligned;
  assign trap       = run & advance & misaligned;
  assign bubble     = (state_q == BUBBLE);

  // Next-state logic: PC update, trap capture, redirect counting, bubble countdown.
  always_comb begin
    state_d        = state_q;
    bcnt_d         = bcnt_q;
    pc_d           = pc;
    fault_pc_d     = fault_pc;
    fault_target_d = fault_target;
    count_d        = taken_count;
    if (state_q == BUBBLE) begin
      bcnt_d = bcnt_q - 2'd1;
      if (bcnt_q == 2'd1) begin
        state_d = RUN;
      end
    end else if (advance) begin
      if (misaligned) begin
        pc_d           = TRAP_VECTOR;
        fault_pc_d     = pc;
        fault_target_d = target;
      end else if (taken) begin
        pc_d = target;
        if (taken_count != '1) begin
          count_d = taken_count + CNT_W'(1);
        end
        if (REDIRECT_BUBBLES > 0) begin
          state_d = BUBBLE;
          bcnt_d  = BUB_INIT;
        end
      end else begin
        pc_d = link_value;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      bcnt_q       <= 2'd0;
      pc           <= RESET_PC;
      fault_pc     <= '0;
      fault_target <= '0;
      taken_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      pc           <= pc_d;
      fault_pc     <= fault_pc_d;
      fault_target <= fault_target_d;
      taken_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed scenarios followed by
// randomized instructions, compared every cycle against a behavioural model.
// Two instances share stimulus: one without bubbles, one with two bubbles and
// a narrow taken counter so saturation is reached.
module tb_branch_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    int          bub;
    logic [31:0] fpc;
    logic [31:0] ftgt;
    int          cnt;
  } mst_t;

  localparam int NB   [2] = '{0, 2};
  localparam int CMAX [2] = '{65535, 15};
  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, advance;
  logic [31:0] instr, rs1_val, rs2_val;

  logic [31:0] pc0, link_value0, fault_pc0, fault_target0;
  logic        link_we0, bubble0, trap0;
  logic [4:0]  link_rd0;
  logic [15:0] tc0;
  logic [31:0] pc2, link_value2, fault_pc2, fault_target2;
  logic        link_we2, bubble2, trap2;
  logic [4:0]  link_rd2;
  logic [3:0]  tc2;

  int   checks = 0;
  int   errors = 0;
  mst_t m   [2];
  mst_t nxt [2];

  branch_pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VECTOR(32'h100),
                        .REDIRECT_BUBBLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .advance(advance), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc0), .link_we(link_we0),
    .link_rd(link_rd0), .link_value(link_value0), .bubble(bubble0),
    .trap(trap0), .fault_pc(fault_pc0), .fault_target(fault_target0),
    .taken_count(tc0));

  branch_pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VECTOR(32'h100),
                        .REDIRECT_BUBBLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .advance(advance), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc2), .link_we(link_we2),
    .link_rd(link_rd2), .link_value(link_value2), .bubble(bubble2),
    .trap(trap2), .fault_pc(fault_pc2), .fault_target(fault_target2),
    .taken_count(tc2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one cycle, written from the instruction semantics.
  task automatic model_step(input mst_t s, input int nb, input int cmax,
                            input logic [31:0] ins, input logic [31:0] r1,
                            input logic [31:0] r2, input logic adv,
                            output logic we, output logic trp, output mst_t ns);
    int          op, f3, rd, imm;
    logic        jump, tk;
    logic [31:0] tgt;
    ns = s; we = 1'b0; trp = 1'b0;
    op = int'(ins & 32'h7f);
    f3 = int'((ins >> 12) & 32'h7);
    rd = int'((ins >> 7) & 32'h1f);
    jump = 1'b0; tk = 1'b0; tgt = 32'h0;
    if (op == 111) begin
      imm = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096
          + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      if (ins[31]) imm -= (1 << 21);
      jump = 1'b1; tk = 1'b1; tgt = s.pc + 32'(imm);
    end else if (op == 103 && f3 == 0) begin
      imm = int'(ins) >>> 20;
      jump = 1'b1; tk = 1'b1; tgt = (r1 + 32'(imm)) & 32'hFFFF_FFFE;
    end else if (op == 99) begin
      imm = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
          + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      if (ins[31]) imm -= 8192;
      tgt = s.pc + 32'(imm);
      case (f3)
        0: tk = (r1 == r2);
        1: tk = (r1 != r2);
        4: tk = ($signed(r1) <  $signed(r2));
        5: tk = ($signed(r1) >= $signed(r2));
        6: tk = (r1 <  r2);
        7: tk = (r1 >= r2);
        default: tk = 1'b0;
      endcase
    end
    if (s.bub > 0) begin
      ns.bub = s.bub - 1;
    end else if (adv) begin
      if (tk && (tgt & 32'h3) != 0) begin
        trp = 1'b1; ns.pc = 32'h100; ns.fpc = s.pc; ns.ftgt = tgt;
      end else if (tk) begin
        ns.pc  = tgt;
        ns.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
        ns.bub = nb;
        we     = jump && (rd != 0);
      end else begin
        ns.pc = s.pc + 32'd4;
      end
    end
  endtask

  task automatic check_dut(input int k, input logic we_e, input logic trp_e);
    string p = (k == 0) ? "d0" : "d2";
    check({p, "_pc"},           (k == 0) ? pc0 : pc2,                     m[k].pc);
    check({p, "_bubble"},       32'((k == 0) ? bubble0 : bubble2),        32'(m[k].bub > 0));
    check({p, "_trap"},         32'((k == 0) ? trap0 : trap2),            32'(trp_e));
    check({p, "_link_we"},      32'((k == 0) ? link_we0 : link_we2),      32'(we_e));
    check({p, "_link_value"},   (k == 0) ? link_value0 : link_value2,     m[k].pc + 32'd4);
    check({p, "_fault_pc"},     (k == 0) ? fault_pc0 : fault_pc2,         m[k].fpc);
    check({p, "_fault_target"}, (k == 0) ? fault_target0 : fault_target2, m[k].ftgt);
    check({p, "_taken_count"},  (k == 0) ? 32'(tc0) : 32'(tc2),           32'(m[k].cnt));
    if (we_e) check({p, "_link_rd"}, 32'((k == 0) ? link_rd0 : link_rd2), 32'(instr[11:7]));
  endtask

  task automatic check_now();
    logic we, trp;
    for (int k = 0; k < 2; k++) begin
      model_step(m[k], NB[k], CMAX[k], instr, rs1_val, rs2_val, advance, we, trp, nxt[k]);
      check_dut(k, we, trp);
    end
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic adv);
    instr = ins; rs1_val = r1; rs2_val = r2; advance = adv;
    #1;
  endtask

  // Called at a falling edge; checks outputs, clocks once, lands on the next falling edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic adv);
    apply(ins, r1, r2, adv);
    check_now();
    @(posedge clk);
    m[0] = nxt[0]; m[1] = nxt[1];
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      m[k].pc = 32'h0; m[k].bub = 0; m[k].fpc = 32'h0; m[k].ftgt = 32'h0; m[k].cnt = 0;
    end
    check_now();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] enc_jal(input int rd, input int imm);
    logic [20:0] v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] enc_jalr(input int rd, input int imm);
    return {12'(imm), 5'd1, 3'b000, 5'(rd), 7'h67};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int imm);
    logic [12:0] v = 13'(imm);
    return {v[12], v[10:5], 5'd2, 5'd1, 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] rand_instr();
    int sel = int'($urandom_range(0, 9));
    int rd  = int'($urandom_range(0, 31));
    if (sel < 3)      return enc_jal(rd, int'($urandom_range(0, 64)) * 2 - 64);
    else if (sel < 5) return enc_jalr(rd, int'($urandom_range(0, 32)) - 16);
    else if (sel < 9) return enc_b(int'($urandom_range(0, 7)), int'($urandom_range(0, 64)) * 2 - 64);
    else              return $urandom();
  endfunction

  initial begin
    logic [31:0] r1, r2;
    reset = 1'b1; advance = 1'b0; instr = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    @(negedge clk);
    do_reset();

    // Sequential step, then JAL x1,+12 at pc 4.
    step(ADDI, 0, 0, 1'b1);
    check("seq_pc", pc0, 32'd4);
    apply(enc_jal(1, 12), 0, 0, 1'b1);
    check("jal_link_we", 32'(link_we0), 32'd1);
    check("jal_link_value", link_value0, 32'd8);
    step(enc_jal(1, 12), 0, 0, 1'b1);
    check("jal_pc", pc0, 32'd16);
    check("jal_count", 32'(tc0), 32'd1);
    step(ADDI, 0, 0, 1'b1);

    // Backward JAL x2,-12 at pc 20, then JAL x0 to self.
    apply(enc_jal(2, -12), 0, 0, 1'b1);
    check("jal_back_link", link_value0, 32'd24);
    step(enc_jal(2, -12), 0, 0, 1'b1);
    check("jal_back_pc", pc0, 32'd8);
    apply(enc_jal(0, 0), 0, 0, 1'b1);
    check("jal_x0_we", 32'(link_we0), 32'd0);
    step(enc_jal(0, 0), 0, 0, 1'b1);
    check("self_jump_pc", pc0, 32'd8);
    check("self_jump_count", 32'(tc0), 32'd3);

    // Branch hold and not-taken.
    step(enc_b(0, 16), 5, 5, 1'b0);
    check("hold_pc", pc0, 32'd8);
    step(enc_b(1, 16), 5, 5, 1'b1);
    check("bne_pc", pc0, 32'd12);

    // Misaligned JAL trap at pc 12.
    apply(enc_jal(1, 2), 0, 0, 1'b1);
    check("mis_trap", 32'(trap0), 32'd1);
    check("mis_we", 32'(link_we0), 32'd0);
    step(enc_jal(1, 2), 0, 0, 1'b1);
    check("mis_pc", pc0, 32'h100);
    check("mis_fault_pc", fault_pc0, 32'd12);
    check("mis_fault_target", fault_target0, 32'd14);

    // Signed versus unsigned comparisons.
    step(enc_b(0, 16), 5, 5, 1'b1);
    check("beq_pc", pc0, 32'h110);
    step(enc_b(4, 8), 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("blt_pc", pc0, 32'h118);
    step(enc_b(6, 8), 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("bltu_pc", pc0, 32'h11c);
    step(enc_b(7, 8), 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("bgeu_pc", pc0, 32'h124);
    step(enc_b(2, 8), 32'd5, 32'd5, 1'b1);
    check("f3_010_pc", pc0, 32'h128);

    // JALR target with bit 0 cleared but still misaligned.
    apply(enc_jalr(0, 0), 32'h103, 0, 1'b1);
    check("jalr_trap", 32'(trap0), 32'd1);
    step(enc_jalr(0, 0), 32'h103, 0, 1'b1);
    check("jalr_fault_target", fault_target0, 32'h102);

    // Top of address space wraps to 0.
    step(enc_jalr(5, 12), 32'hFFFF_FFF0, 0, 1'b1);
    check("jalr_top_pc", pc0, 32'hFFFF_FFFC);
    step(ADDI, 0, 0, 1'b1);
    check("wrap_pc", pc0, 32'h0);

    // Bubble timing on the two-bubble instance.
    do_reset();
    step(enc_jal(1, 8), 0, 0, 1'b1);
    check("bub_pc_a", pc2, 32'd8);
    check("bub_on_a", 32'(bubble2), 32'd1);
    step(ADDI, 0, 0, 1'b1);
    check("bub_pc_b", pc2, 32'd8);
    check("bub_on_b", 32'(bubble2), 32'd1);
    step(ADDI, 0, 0, 1'b1);
    check("bub_pc_c", pc2, 32'd8);
    check("bub_off", 32'(bubble2), 32'd0);
    step(ADDI, 0, 0, 1'b1);
    check("bub_resume_pc", pc2, 32'd12);
    step(enc_jal(1, 8), 0, 0, 1'b1);
    check("bub_pre_reset", 32'(bubble2), 32'd1);
    do_reset();
    check("bub_reset_pc", pc2, 32'h0);
    check("bub_reset_bubble", 32'(bubble2), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r1 = $urandom();
        case ($urandom_range(0, 3))
          0:       r2 = r1;
          1:       begin r1 = 32'(int'($urandom_range(0, 8)) - 4); r2 = 32'(int'($urandom_range(0, 8)) - 4); end
          default: r2 = $urandom();
        endcase
        step(rand_instr(), r1, r2, $urandom_range(0, 3) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
